rob_commit_queue: RTL
=====================

Name: rob_commit_queue

Overview:
- Reorder buffer for the out-of-order core. Sits downstream of dispatch/rename and of the CDB.
- Allocates one entry per dispatched instruction and marks entries done from CDB broadcasts.
- Retires completed entries strictly in program order, presenting {phys_reg, arch_reg} to the RRAT/free-list.
- Shares cdb_t, rob_out_t and rvfi_info from rv32i_types.

Parameters:
ROB_DEPTH, 32, number of entries; power of two, 2..64.
ROB_IDX_W, $clog2(ROB_DEPTH), entry index width. Zero-extended into the 6-bit rob_idx/rob_entry fields.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous squash of all entries
dispatch_valid  in  1  rename presents an instruction
dispatch_ready  out  1  ROB can accept (not full)
dispatch_pd  in  6  destination physical register
dispatch_rd  in  5  destination architectural register
dispatch_rvfi  in  rvfi_info  monitor fields known at dispatch
dispatch_rob_idx  out  6  index allocated this cycle (tail), to reservation stations
cdb  in  cdb_t  completion broadcast
commit_valid  out  1  head entry retiring this cycle
commit_out  out  rob_out_t  {phys_reg, arch_reg} of retiring entry
commit_rvfi  out  rvfi_info  monitor record of retiring entry
rob_empty  out  1  no busy entries

Behaviour:
- Storage per entry: busy, done, pd, rd, rvfi_info. Pointers: head and tail, each ROB_IDX_W+1 bits; the extra bit is the wrap bit.
- Empty: head == tail. Full: indices equal, wrap bits differ.
- Reset (rst_n low, asynchronous): head=tail=0; all busy/done=0.
  - Outputs after reset: dispatch_ready=1, commit_valid=0, commit_out=0, commit_rvfi=0, dispatch_rob_idx=0, rob_empty=1.
- Dispatch: fires when dispatch_valid && dispatch_ready.
  - Writes the tail entry with busy=1, done=0, pd, rd, rvfi. tail+1 on the edge.
  - dispatch_ready = !full, computed from registered pointers only. No same-cycle commit bypass, so a full ROB refuses dispatch even while committing.
  - dispatch_rob_idx = tail index, combinational.
- CDB: when cdb.valid and entry cdb.rob_idx[ROB_IDX_W-1:0] is busy, set done=1 and write monitor_rd_wdata=cdb.rd_v.
  - A broadcast to a non-busy entry is ignored.
  - The CDB cannot target the entry being dispatched in the same cycle.
- Commit: commit_valid = busy[head] && done[head], combinational from registers.
  - When valid: commit_out={pd,rd} of head; commit_rvfi = head rvfi with monitor_valid=1. Otherwise both zero.
  - On the edge, clear busy/done of head; head+1.
  - Minimum latency: CDB in cycle N, commit in cycle N+1. One commit per cycle maximum.
- rd=0 entries commit normally; downstream discards them.
- Simultaneous dispatch and commit: both happen. Occupancy is unchanged; pointers wrap independently at ROB_DEPTH.
- flush (synchronous, highest priority over dispatch, CDB and commit):
  - next state: head=tail=0, all busy/done=0.
  - commit_valid in the flush cycle is still driven from the current state, and downstream must ignore it when flush=1.
- rst_n asserted mid-operation discards all entries immediately.

Optional Feature:
- Macro: ROB_RVFI_EN.
- Defined: per-entry rvfi_info storage as described, and commit_rvfi is driven.
- Undefined: no rvfi storage is synthesised and commit_rvfi is tied to 0. The ports still exist, and busy/done/pd/rd behaviour is identical.

Decomposition:
- rv32i_types gains:
  - ROB_DEPTH_DEFAULT constant;
  - rob_meta_t struct {busy, done, pd[5:0], rd[4:0]}.
- rv32i_types reuses cdb_t, rob_out_t and rvfi_info.
- Sub-module rob_ptr_ctr: wrap-bit pointer, inc/clear inputs, async active-low reset. Instantiated for head and tail.

Test Plan:
- Reset, then dispatch pd=6'd33, rd=5'd5 → dispatch_rob_idx=0, rob_empty=0. CDB rob_idx=0, rd_v=32'hDEAD_BEEF → next cycle commit_valid=1, commit_out={33,5}, commit_rvfi.monitor_rd_wdata=32'hDEADBEEF.
- Dispatch 3 entries; CDB completes idx 2, then 1, then 0 → nothing commits until idx 0 completes. Then idx 0, 1, 2 commit in three consecutive cycles.
- Fill 32 entries → dispatch_ready=0 and a 33rd dispatch_valid is not accepted. Complete idx 0 → commit fires and dispatch_ready rises the following cycle. The next dispatch receives idx 0, wrap bit set.
- Full steady state: dispatch and commit every cycle for 100 cycles → occupancy stays 31 or 32, and the commit order matches the dispatch order.
- CDB to a non-busy idx 7 → no state change. flush with 10 busy entries → next cycle rob_empty=1 and dispatch_rob_idx=0.
- Deassert rst_n mid-stream, asynchronous to clk → outputs reach reset values before the next clock edge. Build with and without ROB_RVFI_EN: with the macro, commit_rvfi matches dispatch data; without it, commit_rvfi=0.

Source files
------------

// File: rtl/rv32i_types.sv
// ---------------------------------------------------------------------------
// rv32i_types
// Shared type package for the out-of-order core.
//   cdb_t      : common data bus broadcast {valid, rob_idx, rd_v}
//   rob_out_t  : retirement record {phys_reg, arch_reg} for RRAT/free-list
//   rvfi_info  : architectural monitor record carried through the ROB
//   rob_meta_t : per-entry ROB control/metadata view {busy, done, pd, rd}
//   ROB_DEPTH_DEFAULT : default reorder buffer depth
// ---------------------------------------------------------------------------
package rv32i_types;

  localparam int ROB_DEPTH_DEFAULT = 32;

  typedef struct packed {
    logic        valid;
    logic [5:0]  rob_idx;
    logic [31:0] rd_v;
  } cdb_t;

  typedef struct packed {
    logic [5:0] phys_reg;
    logic [4:0] arch_reg;
  } rob_out_t;

  typedef struct packed {
    logic        monitor_valid;
    logic [63:0] monitor_order;
    logic [31:0] monitor_inst;
    logic [4:0]  monitor_rs1_addr;
    logic [4:0]  monitor_rs2_addr;
    logic [31:0] monitor_rs1_rdata;
    logic [31:0] monitor_rs2_rdata;
    logic [4:0]  monitor_rd_addr;
    logic [31:0] monitor_rd_wdata;
    logic [31:0] monitor_pc_rdata;
    logic [31:0] monitor_pc_wdata;
    logic [31:0] monitor_mem_addr;
    logic [3:0]  monitor_mem_rmask;
    logic [3:0]  monitor_mem_wmask;
    logic [31:0] monitor_mem_rdata;
    logic [31:0] monitor_mem_wdata;
  } rvfi_info;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [5:0] pd;
    logic [4:0] rd;
  } rob_meta_t;

endpackage

// File: rtl/rob_ptr_ctr.sv
// ---------------------------------------------------------------------------
// rob_ptr_ctr
// Circular-buffer pointer with an extra wrap bit above the index. The wrap
// bit lets the owner tell full (indices equal, wrap bits differ) from empty
// (pointers fully equal). Wraps naturally at 2*depth because depth is a
// power of two.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (pointer -> 0)
//   clear_i  in   synchronous return to 0, priority over inc_i
//   inc_i    in   advance by one entry
//   ptr_o    out  {wrap, index}, IDX_W+1 bits
// ---------------------------------------------------------------------------
module rob_ptr_ctr #(
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [IDX_W:0]   ptr_o
);

  logic [IDX_W:0] ptr_q;
  logic [IDX_W:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + (IDX_W + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/rob_commit_queue.sv
// ---------------------------------------------------------------------------
// rob_commit_queue
// Reorder buffer: allocates one entry per dispatched instruction at the tail,
// marks entries done from CDB broadcasts, and retires done entries strictly
// in program order from the head, at most one per cycle.
//
// Optional feature macro: ROB_RVFI_EN
//   defined   : per-entry rvfi_info storage; commit_rvfi carries the record
//               of the retiring entry with monitor_valid set and
//               monitor_rd_wdata captured from the CDB.
//   undefined : no rvfi storage; commit_rvfi is tied to zero.
//
// Ports:
//   clk              in   clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   flush            in   synchronous squash of all entries (highest priority)
//   dispatch_valid   in   rename presents an instruction
//   dispatch_ready   out  ROB not full (registered pointers only)
//   dispatch_pd      in   destination physical register
//   dispatch_rd      in   destination architectural register
//   dispatch_rvfi    in   monitor fields known at dispatch
//   dispatch_rob_idx out  tail index allocated this cycle (zero-extended)
//   cdb              in   completion broadcast
//   commit_valid     out  head entry retires this cycle
//   commit_out       out  {phys_reg, arch_reg} of retiring entry, else 0
//   commit_rvfi      out  monitor record of retiring entry, else 0
//   rob_empty        out  no busy entries
// ---------------------------------------------------------------------------
module rob_commit_queue
  import rv32i_types::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_DEFAULT,
  parameter int ROB_IDX_W = $clog2(ROB_DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       dispatch_valid,
  output logic       dispatch_ready,
  input  logic [5:0] dispatch_pd,
  input  logic [4:0] dispatch_rd,
  input  rvfi_info   dispatch_rvfi,
  output logic [5:0] dispatch_rob_idx,
  input  cdb_t       cdb,
  output logic       commit_valid,
  output rob_out_t   commit_out,
  output rvfi_info   commit_rvfi,
  output logic       rob_empty
);

  localparam int PTR_W = ROB_IDX_W + 1;

  logic [PTR_W-1:0]     head_ptr;
  logic [PTR_W-1:0]     tail_ptr;
  logic [ROB_IDX_W-1:0] head_idx;
  logic [ROB_IDX_W-1:0] tail_idx;
  logic [ROB_IDX_W-1:0] cdb_idx;

  logic full;
  logic dispatch_fire;
  logic cdb_hit;

  logic [ROB_DEPTH-1:0] busy_q;
  logic [ROB_DEPTH-1:0] busy_d;
  logic [ROB_DEPTH-1:0] done_q;
  logic [ROB_DEPTH-1:0] done_d;

  logic [5:0] pd_q [ROB_DEPTH];
  logic [4:0] rd_q [ROB_DEPTH];

  rob_meta_t head_meta;
  logic      unused_in;

  // Pointers ----------------------------------------------------------------
  rob_ptr_ctr #(
    .IDX_W (ROB_IDX_W)
  ) u_head_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (flush),
    .inc_i   (commit_valid),
    .ptr_o   (head_ptr)
  );

  rob_ptr_ctr #(
    .IDX_W (ROB_IDX_W)
  ) u_tail_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (flush),
    .inc_i   (dispatch_fire),
    .ptr_o   (tail_ptr)
  );

  assign head_idx = head_ptr[ROB_IDX_W-1:0];
  assign tail_idx = tail_ptr[ROB_IDX_W-1:0];

  // Full only looks at registered pointers: a commit in the same cycle does
  // not free a slot for dispatch until the next cycle.
  assign full = (head_idx == tail_idx) &&
                (head_ptr[ROB_IDX_W] != tail_ptr[ROB_IDX_W]);

  assign dispatch_ready   = !full;
  assign dispatch_fire    = dispatch_valid && !full;
  assign dispatch_rob_idx = 6'(tail_idx);
  assign rob_empty        = (head_ptr == tail_ptr);

  // Broadcasts to entries that are not allocated are dropped.
  assign cdb_idx = cdb.rob_idx[ROB_IDX_W-1:0];
  assign cdb_hit = cdb.valid && busy_q[cdb_idx];

  // Head view and commit outputs ---------------------------------------------
  always_comb begin
    head_meta      = '0;
    head_meta.busy = busy_q[head_idx];
    head_meta.done = done_q[head_idx];
    head_meta.pd   = pd_q[head_idx];
    head_meta.rd   = rd_q[head_idx];
  end

  assign commit_valid = head_meta.busy && head_meta.done;

  always_comb begin
    commit_out = '0;
    if (commit_valid) begin
      commit_out.phys_reg = head_meta.pd;
      commit_out.arch_reg = head_meta.rd;
    end
  end

  // Busy/done control ---------------------------------------------------------
  // CDB is applied before the commit clear so a late broadcast to the head
  // that is retiring cannot re-mark a freed slot as done.
  always_comb begin
    busy_d = busy_q;
    done_d = done_q;
    if (flush) begin
      busy_d = '0;
      done_d = '0;
    end else begin
      if (cdb_hit) begin
        done_d[cdb_idx] = 1'b1;
      end
      if (commit_valid) begin
        busy_d[head_idx] = 1'b0;
        done_d[head_idx] = 1'b0;
      end
      if (dispatch_fire) begin
        busy_d[tail_idx] = 1'b1;
        done_d[tail_idx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      done_q <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Entry payload -------------------------------------------------------------
  // Payload is only observed through busy/done, so it carries no reset.
  always_ff @(posedge clk) begin
    if (dispatch_fire) begin
      pd_q[tail_idx] <= dispatch_pd;
      rd_q[tail_idx] <= dispatch_rd;
    end
  end

`ifdef ROB_RVFI_EN
  rvfi_info rvfi_q [ROB_DEPTH];

  // Dispatch and CDB never target the same entry in one cycle, so the two
  // writes below never collide.
  always_ff @(posedge clk) begin
    if (dispatch_fire) begin
      rvfi_q[tail_idx] <= dispatch_rvfi;
    end
    if (cdb_hit) begin
      rvfi_q[cdb_idx].monitor_rd_wdata <= cdb.rd_v;
    end
  end

  always_comb begin
    commit_rvfi = '0;
    if (commit_valid) begin
      commit_rvfi               = rvfi_q[head_idx];
      commit_rvfi.monitor_valid = 1'b1;
    end
  end

  assign unused_in = ^{cdb.rob_idx};
`else
  assign commit_rvfi = '0;
  assign unused_in   = ^{cdb.rob_idx, cdb.rd_v, dispatch_rvfi};
`endif

endmodule
